// File: rtl/fifo_sys_pkg.sv
// Shared types and default sizes for the KEY/switch driven SDRAM FIFO system.
package fifo_sys_pkg;
    localparam int DEPTH_LOG2_DEF = 4;
    localparam int DATA_W_DEF     = 4;
    localparam int MEM_W          = 16;
    localparam int ADDR_W_DEF     = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;
endpackage

// File: rtl/fifo_ptr_count.sv
// Head/tail pointers and occupancy count for the SDRAM-backed FIFO.
module fifo_ptr_count
    import fifo_sys_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_wr,
    input  logic                  inc_rd,
    output logic [DEPTH_LOG2-1:0] wr_ptr,
    output logic [DEPTH_LOG2-1:0] rd_ptr,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Pointers wrap naturally at DEPTH; count alone decides full/empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (inc_wr) wr_ptr <= wr_ptr + 1'b1;
            if (inc_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({inc_wr, inc_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO sequencer: turns write/read pulses into addressed SDRAM requests,
// tracks occupancy and reports overflow/underflow/timeout conditions.
module fifo_ptr_ctrl
    import fifo_sys_pkg::*;
#(
    parameter int          DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_W-1:0]     din,
    output logic                  mem_wr_req,
    output logic                  mem_rd_req,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [MEM_W-1:0]      mem_wdata,
    input  logic                  mem_done,
    input  logic [MEM_W-1:0]      mem_rdata,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  busy,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  timeout_err
);
    localparam int TCNT_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    state_t                  state, next_state;
    logic                    wr_pend, rd_pend;
    logic [DATA_W-1:0]       wdata_q;
    logic [TCNT_W-1:0]       tcnt;
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic                    inc_wr, inc_rd;
    logic                    clr_wr, clr_rd;
    logic                    rej_wr, rej_rd;
    logic                    abort;

    fifo_ptr_count #(.DEPTH_LOG2(DEPTH_LOG2)) u_ptr_count (
        .clk    (clk),
        .rst    (rst),
        .inc_wr (inc_wr),
        .inc_rd (inc_rd),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Full/empty are judged at service time; a rejected command never reaches the SDRAM.
    always_comb begin
        next_state = state;
        inc_wr     = 1'b0;
        inc_rd     = 1'b0;
        clr_wr     = 1'b0;
        clr_rd     = 1'b0;
        rej_wr     = 1'b0;
        rej_rd     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (wr_pend) begin
                    if (full) begin
                        clr_wr = 1'b1;
                        rej_wr = 1'b1;
                    end else begin
                        next_state = WRITE;
                    end
                end else if (rd_pend) begin
                    if (empty) begin
                        clr_rd = 1'b1;
                        rej_rd = 1'b1;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            WRITE: begin
                if (mem_done) begin
                    inc_wr     = 1'b1;
                    clr_wr     = 1'b1;
                    next_state = IDLE;
                end else if (tcnt == TCNT_LAST) begin
                    clr_wr     = 1'b1;
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            READ: begin
                if (mem_done) begin
                    inc_rd     = 1'b1;
                    clr_rd     = 1'b1;
                    next_state = IDLE;
                end else if (tcnt == TCNT_LAST) begin
                    clr_rd     = 1'b1;
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A second command of the same kind while one is pending is dropped,
    // which also keeps wdata_q frozen for the whole WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_pend     <= 1'b0;
            rd_pend     <= 1'b0;
            wdata_q     <= '0;
            tcnt        <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= next_state;
            tcnt  <= (state == IDLE) ? '0 : tcnt + 1'b1;

            if (wr && !wr_pend) begin
                wr_pend <= 1'b1;
                wdata_q <= din;
            end else if (clr_wr) begin
                wr_pend <= 1'b0;
            end

            if (rd && !rd_pend) begin
                rd_pend <= 1'b1;
            end else if (clr_rd) begin
                rd_pend <= 1'b0;
            end

            overflow   <= (wr && wr_pend) || rej_wr;
            underflow  <= (rd && rd_pend) || rej_rd;
            dout_valid <= inc_rd;
            if (inc_rd) dout <= mem_rdata[DATA_W-1:0];
            if (abort) timeout_err <= 1'b1;
        end
    end

    assign mem_wr_req = (state == WRITE);
    assign mem_rd_req = (state == READ);
    assign busy       = (state != IDLE);
    assign mem_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'((state == READ) ? rd_ptr : wr_ptr);
    assign mem_wdata  = MEM_W'(wdata_q);
endmodule
